// File: rtl/data_mem_lsu.sv
// ---------------------------------------------------------------------------
// data_mem_lsu
// Data-side memory stage for a single-cycle RISC-V core. The core's aluout
// arrives as the byte address. This block does the following:
//   - selects byte and half lanes,
//   - sign- or zero-extends loads,
//   - checks alignment and legality,
//   - owns a byte-lane word RAM and two MMIO registers (tohost, cycle counter).
// Loads are combinational so they fit inside the core's single cycle. All
// state changes happen on the rising clock edge.
//
// Ports
//   clk           in   1   clock, all state updates on posedge
//   reset         in   1   asynchronous, active-low
//   memwrite      in   1   store strobe for the current cycle
//   memsize       in   3   funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr          in   32  byte address
//   writedata     in   32  right-aligned store data
//   readdata      out  32  extended load result (0 on a faulted access)
//   fault         out  1   misaligned / unmapped / illegal-size access
//   tohost        out  32  last value stored to MMIO_BASE
//   tohost_valid  out  1   one-cycle pulse after each accepted tohost store
// ---------------------------------------------------------------------------
module data_mem_lsu #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [2:0]  memsize,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        fault,
    output logic [31:0] tohost,
    output logic        tohost_valid
);

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES  = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] CYCLE_ADDR = MMIO_BASE + 32'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] tohost_reg, tohost_next;
    logic        tohost_valid_reg, tohost_valid_next;
    logic [31:0] cycle_reg, cycle_next;
    // Clears with reset and sets on the first edge after release. Gating
    // every store with it drops the store that coincides with the releasing
    // edge.
    logic        wr_en_reg;

    // ------------------------------------------------------------------
    // Address decode and fault detection
    // ------------------------------------------------------------------
    logic is_ram, is_tohost, is_cycle, is_mmio;
    logic size_bad, store_bad, half_misal, word_misal, unmapped, mmio_bad;

    assign is_ram    = (addr < RAM_BYTES);
    assign is_tohost = (addr == MMIO_BASE);
    assign is_cycle  = (addr == CYCLE_ADDR);
    assign is_mmio   = is_tohost | is_cycle;

    assign size_bad   = (memsize == 3'b011) | (memsize == 3'b110) | (memsize == 3'b111);
    // Unsigned variants only exist for loads.
    assign store_bad  = memwrite & memsize[2];
    assign half_misal = (memsize[1:0] == 2'b01) & addr[0];
    assign word_misal = (memsize[1:0] == 2'b10) & (addr[1:0] != 2'b00);
    assign unmapped   = ~(is_ram | is_mmio);
    assign mmio_bad   = is_mmio & (memsize != 3'b010);

    assign fault = size_bad | store_bad | half_misal | word_misal | unmapped | mmio_bad;

    logic store_ok;
    assign store_ok = memwrite & ~fault & wr_en_reg;

    // ------------------------------------------------------------------
    // Byte-lane RAM: one 8-bit array per lane gives a natural byte-enable
    // write without read-modify-write.
    // ------------------------------------------------------------------
    logic [AW-1:0] word_idx;
    logic [3:0]    lane_sel;
    logic [3:0]    lane_we;
    logic [7:0]    lane_wdata [4];
    logic [31:0]   ram_word;

    assign word_idx = addr[AW+1:2];

    always_comb begin
        lane_sel = 4'b0000;
        case (memsize[1:0])
            2'b00:   lane_sel = 4'b0001 << addr[1:0];
            2'b01:   lane_sel = addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_sel = 4'b1111;
            default: lane_sel = 4'b0000;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH_WORDS-1];

            // Store data is right-aligned: a byte store replicates [7:0]
            // onto every lane, and a half store replicates [15:0].
            assign lane_wdata[gi] = (memsize[1:0] == 2'b00) ? writedata[7:0] :
                                    (memsize[1:0] == 2'b01) ? writedata[8*(gi%2) +: 8] :
                                                              writedata[8*gi +: 8];

            assign lane_we[gi] = store_ok & is_ram & lane_sel[gi];

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[word_idx] <= lane_wdata[gi];
                end
            end

            // Asynchronous read: a same-cycle store shows old data until
            // the edge.
            assign ram_word[8*gi +: 8] = lane_mem[word_idx];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = ram_word[7:0];
        case (addr[1:0])
            2'b00: byte_sel = ram_word[7:0];
            2'b01: byte_sel = ram_word[15:8];
            2'b10: byte_sel = ram_word[23:16];
            2'b11: byte_sel = ram_word[31:24];
        endcase
    end

    assign half_sel = addr[1] ? ram_word[31:16] : ram_word[15:0];

    always_comb begin
        readdata = 32'h0;
        if (!fault) begin
            if (is_tohost) begin
                readdata = tohost_reg;
            end else if (is_cycle) begin
                readdata = cycle_reg;
            end else begin
                case (memsize)
                    3'b000:  readdata = {{24{byte_sel[7]}}, byte_sel};
                    3'b001:  readdata = {{16{half_sel[15]}}, half_sel};
                    3'b010:  readdata = ram_word;
                    3'b100:  readdata = {24'h0, byte_sel};
                    3'b101:  readdata = {16'h0, half_sel};
                    default: readdata = 32'h0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    logic tohost_we;
    // A store to the CYCLE address is accepted without fault but has no
    // effect, so only the tohost address has a write enable.
    assign tohost_we = store_ok & is_tohost;

    always_comb begin
        tohost_next       = tohost_we ? writedata : tohost_reg;
        tohost_valid_next = tohost_we;
        cycle_next        = cycle_reg + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_reg        <= 1'b0;
            tohost_reg       <= 32'h0;
            tohost_valid_reg <= 1'b0;
            cycle_reg        <= 32'h0;
        end else begin
            wr_en_reg        <= 1'b1;
            tohost_reg       <= tohost_next;
            tohost_valid_reg <= tohost_valid_next;
            cycle_reg        <= cycle_next;
        end
    end

    assign tohost       = tohost_reg;
    assign tohost_valid = tohost_valid_reg;

endmodule
